// File: rtl/fetch_stage_pkg.sv
// Shared pipeline definitions: datapath width, canonical NOP and fetch FSM states.
package fetch_stage_pkg;

   localparam int XLEN = 32;
   localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_HOLD = 2'd2,
      S_DROP = 2'd3
   } fetch_state_t;

endpackage

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC, single-outstanding imem request FSM, hold buffer and IF/ID register.
//
// state  | meaning
// -------+------------------------------------------------------------
// S_IDLE | request imem at pc (suppressed during a flush)
// S_WAIT | one request outstanding, waiting for imem_rvalid
// S_HOLD | response parked in hold_buf while IF/ID is stalled
// S_DROP | outstanding response belongs to a squashed path; discard it
module fetch_stage
   import fetch_stage_pkg::*;
#(
   parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            pc_write,
   input  logic            if_id_write,
   input  logic            if_flush,
   input  logic [XLEN-1:0] branch_target,
   output logic            imem_req,
   output logic [XLEN-1:0] imem_addr,
   input  logic            imem_ready,
   input  logic            imem_rvalid,
   input  logic [XLEN-1:0] imem_rdata,
   output logic [XLEN-1:0] if_id_pc,
   output logic [XLEN-1:0] if_id_instr,
   output logic            if_id_valid
);

   fetch_state_t    state;
   logic [XLEN-1:0] pc;
   logic [XLEN-1:0] hold_buf;

   logic            deliver;
   logic [XLEN-1:0] deliver_word;

   always_comb begin
      imem_req     = (state == S_IDLE) && !if_flush && !rst;
      imem_addr    = pc;
      deliver      = !if_flush && if_id_write &&
                     (((state == S_WAIT) && imem_rvalid) || (state == S_HOLD));
      deliver_word = (state == S_HOLD) ? hold_buf : imem_rdata;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= S_IDLE;
         pc          <= RESET_PC;
         hold_buf    <= '0;
         if_id_pc    <= '0;
         if_id_instr <= NOP_INSTR;
         if_id_valid <= 1'b0;
      end else if (if_flush) begin
         pc          <= branch_target;
         hold_buf    <= '0;
         if_id_instr <= NOP_INSTR;
         if_id_valid <= 1'b0;
         // A request still in flight must be swallowed before issuing on the new path.
         case (state)
            S_WAIT:  state <= imem_rvalid ? S_IDLE : S_DROP;
            S_DROP:  state <= imem_rvalid ? S_IDLE : S_DROP;
            default: state <= S_IDLE;
         endcase
      end else begin
         case (state)
            S_IDLE: begin
               if (imem_req && imem_ready) state <= S_WAIT;
            end
            S_WAIT: begin
               if (imem_rvalid) begin
                  if (if_id_write) begin
                     state <= S_IDLE;
                  end else begin
                     hold_buf <= imem_rdata;
                     state    <= S_HOLD;
                  end
               end
            end
            S_HOLD: begin
               if (if_id_write) state <= S_IDLE;
            end
            S_DROP: begin
               if (imem_rvalid) state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase

         if (deliver) begin
            if_id_pc    <= pc;
            if_id_instr <= deliver_word;
            if_id_valid <= 1'b1;
            if (pc_write) pc <= pc + XLEN'(4);
         end else if (if_id_write) begin
            if_id_instr <= NOP_INSTR;
            if_id_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed vector table, corner-case sequences, random vs. model.
module tb_fetch_stage;

   localparam logic [31:0] NOP = 32'h0000_0013;
   localparam logic [31:0] W0  = 32'h00A0_0093;
   localparam logic [31:0] W1  = 32'h0020_8133;

   logic        clk = 1'b0;
   logic        rst;
   logic        pc_write, if_id_write, if_flush;
   logic [31:0] branch_target;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ready, imem_rvalid;
   logic [31:0] imem_rdata;
   logic [31:0] if_id_pc, if_id_instr;
   logic        if_id_valid;

   int checks = 0;
   int passed = 0;

   fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
      .clk(clk), .rst(rst), .pc_write(pc_write), .if_id_write(if_id_write),
      .if_flush(if_flush), .branch_target(branch_target), .imem_req(imem_req),
      .imem_addr(imem_addr), .imem_ready(imem_ready), .imem_rvalid(imem_rvalid),
      .imem_rdata(imem_rdata), .if_id_pc(if_id_pc), .if_id_instr(if_id_instr),
      .if_id_valid(if_id_valid)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
   endtask

   typedef struct {
      logic        r, pw, iw, fl;
      logic [31:0] bt;
      logic        rdy, rv;
      logic [31:0] rd;
      logic        e_req;
      logic [31:0] e_addr;
      logic        e_valid;
      logic [31:0] e_pc, e_instr;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(logic r, logic pw, logic iw, logic fl, logic [31:0] bt,
                               logic rdy, logic rv, logic [31:0] rd, logic e_req,
                               logic [31:0] e_addr, logic e_valid, logic [31:0] e_pc,
                               logic [31:0] e_instr);
      vec_t v;
      v.r = r; v.pw = pw; v.iw = iw; v.fl = fl; v.bt = bt; v.rdy = rdy; v.rv = rv;
      v.rd = rd; v.e_req = e_req; v.e_addr = e_addr; v.e_valid = e_valid;
      v.e_pc = e_pc; v.e_instr = e_instr;
      return v;
   endfunction

   // Drive at negedge, check request side before the edge, check IF/ID after it.
   task automatic step(input vec_t v, input string tag);
      @(negedge clk);
      rst = v.r; pc_write = v.pw; if_id_write = v.iw; if_flush = v.fl;
      branch_target = v.bt; imem_ready = v.rdy; imem_rvalid = v.rv; imem_rdata = v.rd;
      #1;
      chk({tag, ".req"}, {31'd0, imem_req}, {31'd0, v.e_req});
      chk({tag, ".addr"}, imem_addr, v.e_addr);
      @(posedge clk);
      #1;
      chk({tag, ".valid"}, {31'd0, if_id_valid}, {31'd0, v.e_valid});
      chk({tag, ".pc"}, if_id_pc, v.e_pc);
      chk({tag, ".instr"}, if_id_instr, v.e_instr);
   endtask

   // Behavioural reference: tracks "request in flight", "in flight but squashed", "word parked".
   logic        m_out, m_disc, m_buffd;
   logic [31:0] m_pc, m_buf, m_ipc, m_instr;
   logic        m_valid;
   logic        mem_busy;
   int          mem_wait;
   logic [31:0] mem_addr;

   task automatic model_reset();
      m_out = 0; m_disc = 0; m_buffd = 0; m_pc = 0; m_buf = 0;
      m_ipc = 0; m_instr = NOP; m_valid = 0; mem_busy = 0; mem_wait = 0;
   endtask

   function automatic logic [31:0] mem_word(logic [31:0] a);
      return (a * 32'd2654435761) ^ 32'h0000_0013;
   endfunction

   task automatic rand_cycle(input int n);
      logic req, hs, delivered;
      logic [31:0] word;
      @(negedge clk);
      pc_write      = ($urandom_range(0, 3) != 0);
      if_id_write   = ($urandom_range(0, 2) != 0);
      if_flush      = ($urandom_range(0, 9) == 0);
      branch_target = {$urandom_range(0, 32'h3FFF), 2'b00};
      if ($urandom_range(0, 19) == 0) branch_target = 32'hFFFF_FFF8;
      imem_ready    = ($urandom_range(0, 2) != 0);
      imem_rvalid   = mem_busy && (mem_wait == 0);
      imem_rdata    = imem_rvalid ? mem_word(mem_addr) : $urandom;
      req = !m_out && !m_buffd && !if_flush;
      hs  = req && imem_ready;
      #1;
      chk($sformatf("rnd%0d.req", n), {31'd0, imem_req}, {31'd0, req});
      chk($sformatf("rnd%0d.addr", n), imem_addr, m_pc);

      delivered = 0;
      word = 0;
      if (if_flush) begin
         m_pc = branch_target; m_valid = 0; m_instr = NOP; m_buffd = 0; m_buf = 0;
         if (m_out && imem_rvalid) begin m_out = 0; m_disc = 0; end
         else if (m_out) m_disc = 1;
      end else begin
         if (m_out && imem_rvalid) begin
            m_out = 0;
            if (!m_disc) begin
               if (if_id_write) begin delivered = 1; word = imem_rdata; end
               else begin m_buffd = 1; m_buf = imem_rdata; end
            end
            m_disc = 0;
         end else if (m_buffd && if_id_write) begin
            delivered = 1; word = m_buf; m_buffd = 0;
         end else if (hs) begin
            m_out = 1;
         end
         if (delivered) begin
            m_ipc = m_pc; m_instr = word; m_valid = 1;
            if (pc_write) m_pc = m_pc + 32'd4;
         end else if (if_id_write) begin
            m_instr = NOP; m_valid = 0;
         end
      end

      if (imem_rvalid) mem_busy = 0;
      else if (mem_busy) mem_wait--;
      if (hs) begin
         mem_busy = 1; mem_wait = $urandom_range(0, 2); mem_addr = imem_addr;
      end

      @(posedge clk);
      #1;
      chk($sformatf("rnd%0d.valid", n), {31'd0, if_id_valid}, {31'd0, m_valid});
      chk($sformatf("rnd%0d.pc", n), if_id_pc, m_ipc);
      chk($sformatf("rnd%0d.instr", n), if_id_instr, m_instr);
   endtask

   initial begin
      rst = 1; pc_write = 0; if_id_write = 0; if_flush = 0; branch_target = 0;
      imem_ready = 0; imem_rvalid = 0; imem_rdata = 0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst.req", {31'd0, imem_req}, 32'd0);
      chk("rst.addr", imem_addr, 32'd0);
      chk("rst.valid", {31'd0, if_id_valid}, 32'd0);
      chk("rst.instr", if_id_instr, NOP);

      //            r  pw iw fl bt  rdy rv rd   req addr  val pc  instr
      // back-to-back fetches at 0,4,8
      vecs.push_back(mk(0, 1, 1, 0, 0, 1, 0, 0,  1, 0,  0, 0, NOP));
      vecs.push_back(mk(0, 1, 1, 0, 0, 1, 1, W0, 0, 0,  1, 0, W0));
      vecs.push_back(mk(0, 1, 1, 0, 0, 1, 0, 0,  1, 4,  0, 0, NOP));
      vecs.push_back(mk(0, 1, 1, 0, 0, 1, 1, W0, 0, 4,  1, 4, W0));
      vecs.push_back(mk(0, 1, 1, 0, 0, 1, 0, 0,  1, 8,  0, 4, NOP));
      vecs.push_back(mk(0, 1, 1, 0, 0, 1, 1, W0, 0, 8,  1, 8, W0));
      // reset, one fetch, then stall a response in the hold buffer for 3 cycles
      vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0,  0, 0,  0, 0, NOP));
      vecs.push_back(mk(0, 1, 1, 0, 0, 1, 0, 0,  1, 0,  0, 0, NOP));
      vecs.push_back(mk(0, 1, 1, 0, 0, 1, 1, W0, 0, 0,  1, 0, W0));
      vecs.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0,  1, 4,  1, 0, W0));
      vecs.push_back(mk(0, 0, 0, 0, 0, 1, 1, W1, 0, 4,  1, 0, W0));
      vecs.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0,  0, 4,  1, 0, W0));
      vecs.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0,  0, 4,  1, 0, W0));
      vecs.push_back(mk(0, 1, 1, 0, 0, 1, 0, 0,  0, 4,  1, 4, W1));
      // pc_write with nothing accepted leaves the PC alone
      vecs.push_back(mk(0, 1, 1, 0, 0, 0, 0, 0,  1, 8,  0, 4, NOP));
      vecs.push_back(mk(0, 1, 1, 0, 0, 0, 0, 0,  1, 8,  0, 4, NOP));
      foreach (vecs[i]) step(vecs[i], $sformatf("vec%0d", i));

      // flush while waiting, late response dropped
      step(mk(0, 1, 1, 0, 0,     1, 0, 0,            1, 8,     0, 4, NOP), "flw.issue");
      step(mk(0, 1, 1, 1, 32'h100, 1, 0, 0,          0, 8,     0, 4, NOP), "flw.flush");
      step(mk(0, 1, 1, 0, 0,     1, 0, 0,            0, 32'h100, 0, 4, NOP), "flw.drop");
      step(mk(0, 1, 1, 0, 0,     1, 1, 32'hDEADBEEF, 0, 32'h100, 0, 4, NOP), "flw.late");
      step(mk(0, 1, 1, 0, 0,     1, 0, 0,            1, 32'h100, 0, 4, NOP), "flw.next");
      // flush coincident with the response
      step(mk(0, 1, 1, 1, 32'h200, 1, 1, 32'h12345678, 0, 32'h100, 0, 4, NOP), "flr.flush");
      step(mk(0, 1, 1, 0, 0,     1, 0, 0,            1, 32'h200, 0, 4, NOP), "flr.next");

      // reset asserted while waiting takes effect immediately
      @(negedge clk);
      rst = 1; imem_ready = 0;
      #1;
      chk("rstw.req", {31'd0, imem_req}, 32'd0);
      chk("rstw.addr", imem_addr, 32'd0);
      chk("rstw.valid", {31'd0, if_id_valid}, 32'd0);
      chk("rstw.pc", if_id_pc, 32'd0);
      chk("rstw.instr", if_id_instr, NOP);
      step(mk(0, 1, 1, 0, 0, 0, 1, 32'hBAD0BAD0, 1, 0, 0, 0, NOP), "rstw.stale");
      step(mk(0, 1, 1, 0, 0, 1, 0, 0,            1, 0, 0, 0, NOP), "rstw.issue");
      step(mk(0, 1, 1, 0, 0, 1, 1, 32'h11,       0, 0, 1, 0, 32'h11), "rstw.resp");

      // PC wrap at the top of the address space
      step(mk(0, 1, 1, 1, 32'hFFFF_FFFC, 1, 0, 0, 0, 4, 0, 0, NOP), "wrap.flush");
      step(mk(0, 1, 1, 0, 0, 1, 0, 0,     1, 32'hFFFF_FFFC, 0, 0, NOP), "wrap.issue");
      step(mk(0, 1, 1, 0, 0, 1, 1, 32'h22, 0, 32'hFFFF_FFFC, 1, 32'hFFFF_FFFC, 32'h22), "wrap.resp");
      step(mk(0, 1, 1, 0, 0, 0, 0, 0,     1, 0, 0, 32'hFFFF_FFFC, NOP), "wrap.next");

      // random traffic against the behavioural model
      @(negedge clk);
      rst = 1; imem_rvalid = 0; if_flush = 0;
      model_reset();
      @(negedge clk);
      rst = 0;
      for (int n = 0; n < 600; n++) rand_cycle(n);

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got no completion expected finish");
      $fatal(1);
   end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter: RESET_PC, 32'h0000_0000, PC value loaded on reset.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 pc_write  input  1  PC may advance when 1 (from hazard unit).
REQ-005 if_id_write  input  1  IF/ID register may load when 1 (from hazard unit).
REQ-006 if_flush  input  1  redirect: squash IF/ID, load PC from branch_target.
REQ-007 branch_target  input  32  redirect PC.
REQ-008 imem_req  output  1  instruction-memory request valid.
REQ-009 imem_addr  output  32  request address (= current PC).
REQ-010 imem_ready  input  1  memory accepts the request when imem_req && imem_ready.
REQ-011 imem_rvalid  input  1  response data valid.
REQ-012 imem_rdata  input  32  response instruction word.
REQ-013 if_id_pc  output  32  PC of instruction held in IF/ID.
REQ-014 if_id_instr  output  32  instruction held in IF/ID.
REQ-015 if_id_valid  output  1  IF/ID contents are a real instruction.

Function
REQ-016 FSM states: IDLE (issue request), WAIT (one request outstanding), HOLD (response buffered, IF/ID stalled), DROP (outstanding response to be discarded).
REQ-017 imem_req = (state==IDLE) && !if_flush; imem_addr = pc, combinational; at most one outstanding request.
REQ-018 IDLE: request handshake -> WAIT; no handshake -> stay IDLE.
REQ-019 WAIT, imem_rvalid=1, if_id_write=1: IF/ID loads {pc, imem_rdata, valid=1}; pc <= pc+4 if pc_write=1; -> IDLE.
REQ-020 WAIT, imem_rvalid=1, if_id_write=0: imem_rdata captured in a 32-bit hold buffer; -> HOLD; PC unchanged.
REQ-021 HOLD, if_id_write=1: IF/ID loads {pc, buffer, valid=1}; pc <= pc+4 if pc_write=1; -> IDLE.
REQ-022 Any cycle with if_id_write=1 and no instruction delivered: if_id_valid <= 0, if_id_instr <= NOP (32'h0000_0013), if_id_pc unchanged.
REQ-023 if_id_write=0 and no flush: IF/ID holds all fields.
REQ-024 if_flush=1 overrides all else: pc <= branch_target; if_id_valid <= 0; if_id_instr <= NOP; hold buffer discarded.
REQ-025 Flush next state: IDLE->IDLE; WAIT with imem_rvalid=0 -> DROP; WAIT with imem_rvalid=1 -> IDLE (data discarded); HOLD -> IDLE; DROP -> DROP unless imem_rvalid=1, then IDLE.
REQ-026 DROP without flush: imem_rvalid=1 -> IDLE, data discarded, IF/ID not loaded; else stay DROP.
REQ-027 PC arithmetic 32-bit, wraps modulo 2^32 (32'hFFFF_FFFC + 4 = 0).
REQ-028 Minimum latency: handshake in cycle N, rvalid in N+1 -> IF/ID valid after edge ending N+1; peak throughput one instruction per 2 cycles.
REQ-029 pc_write=1 with no instruction accepted leaves PC unchanged.

Reset
REQ-030 rst=1 asynchronously forces: pc=RESET_PC, state=IDLE, if_id_valid=0, if_id_instr=NOP, if_id_pc=0, hold buffer=0; imem_req=0 while rst=1.
REQ-031 Reset mid-transaction abandons the outstanding request; a response arriving after reset release while in IDLE is ignored.
REQ-032 First request issued in the first cycle after rst deasserts, address RESET_PC.

Structure
REQ-033 Shared pipeline package holds: XLEN=32, NOP_INSTR=32'h0000_0013, fetch FSM state enum.
REQ-034 Single module, no sub-modules; PC, FSM, hold buffer and IF/ID register all local.

Verification
REQ-035 Reset, imem_ready=1, rvalid one cycle after each grant, rdata=32'h00A00093 -> imem_addr 0,4,8; if_id_instr=32'h00A00093, if_id_valid=1 with if_id_pc 0,4,8.
REQ-036 Response arrives with if_id_write=0 and pc_write=0 for 3 cycles -> HOLD, IF/ID unchanged, pc=4; on release IF/ID={4, buffered word, 1}, pc=8.
REQ-037 if_flush=1, branch_target=32'h0000_0100 while in WAIT, rvalid 2 cycles later -> if_id_valid=0, if_id_instr=NOP, late response discarded, next imem_addr=32'h0000_0100.
REQ-038 if_flush=1 coincident with rvalid in WAIT -> data discarded, state IDLE, next request address branch_target.
REQ-039 rst asserted during WAIT -> all outputs at reset values at once; response after release ignored; first request address RESET_PC.
REQ-040 pc=32'hFFFF_FFFC, instruction accepted with pc_write=1 -> pc=32'h0000_0000.
